serial_adder_ctrl: RTL and testbench

//  Sequencer that reuses the existing 2-bit adder slice to add two WIDTH-bit operands serially,
//  2 bits per clock, LSB slice first, with carry chained between slices.

---
 rtl/serial_adder_ctrl_pkg.sv | 14 +
 rtl/serial_adder_ctrl_adder_2bit.sv | 14 +
 rtl/serial_adder_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the serial adder sequencer.
//   state_t : FSM encoding (IDLE/RUN/DONE)
//   SLICE_W : bits consumed per clock by the shared adder slice
package serial_adder_ctrl_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_adder_2bit.sv
// Existing 2-bit adder slice: {c,s} = a + b.
//   a, b : 2-bit addends
//   s    : 2-bit sum
//   c    : carry out
module adder_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] s,
  output logic       c
);

  assign {c, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/serial_adder_ctrl.sv
// Serial WIDTH-bit adder: reuses one 2-bit slice, LSB slice first, carry
// chained through carry_q. One result every NSLICE+2 cycles.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, accepted only while ready
//   A, B         : operands, sampled on the accepting edge
//   ready/busy   : idle / processing slices (decoded from state)
//   done         : one-cycle pulse, Sum/Carry hold the new result
//   Sum, Carry   : registered result {Carry,Sum} = A+B
// WIDTH must be even and >= 2.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_psum, r_sum;
  logic             r_carry_q, r_carry;
  logic [CW-1:0]    r_cnt;

  logic [1:0]       w_s0, w_s;
  logic             w_c0, w_c1, w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_psum_nxt;

  // Carry-in is folded in by a second slice; 3+3+1 <= 7 so c0/c1 never both set.
  adder_2bit u0 (.a(r_a[1:0]), .b(r_b[1:0]),         .s(w_s0), .c(w_c0));
  adder_2bit u1 (.a(w_s0),     .b({1'b0, r_carry_q}), .s(w_s),  .c(w_c1));

  assign w_c    = w_c0 | w_c1;
  assign w_last = (r_cnt == CW'(NSLICE - 1));

  // New slice sum enters at the MSB; after NSLICE shifts it lines up at bit 0.
  always_comb begin
    w_psum_nxt = r_psum >> SLICE_W;
    w_psum_nxt[WIDTH-1 -: SLICE_W] = w_s;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath. Sum/Carry only move on entry to DONE, so they hold the
  // previous result through RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_psum    <= '0;
      r_carry_q <= 1'b0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a       <= A;
            r_b       <= B;
            r_carry_q <= 1'b0;
            r_cnt     <= '0;
          end
        end
        ST_RUN: begin
          r_a       <= r_a >> SLICE_W;
          r_b       <= r_b >> SLICE_W;
          r_psum    <= w_psum_nxt;
          r_carry_q <= w_c;
          r_cnt     <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_psum_nxt;
            r_carry <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign Sum   = r_sum;
  assign Carry = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W = 8;
  localparam int NS = W / 2;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] A, B;
  logic         ready, busy, done, Carry;
  logic [W-1:0] Sum;

  int tests = 0;
  int fails = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .ready(ready), .busy(busy), .done(done), .Sum(Sum), .Carry(Carry)
  );

  always #5 clk = ~clk;

  // advance one edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One directed operation from IDLE. If mess is set, start is raised with
  // other operands throughout RUN, and A/B are scrambled after acceptance.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit mess);
    logic [W:0]   exp_res;
    logic [W-1:0] prev_sum;
    logic         prev_c;
    exp_res  = {1'b0, a} + {1'b0, b};
    prev_sum = Sum;
    prev_c   = Carry;
    chk({tag, ".ready"}, 32'(ready), 32'd1);
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < NS; i++) begin
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".nodone"}, 32'(done), 32'd0);
      chk({tag, ".hold"}, 32'({prev_c, prev_sum}), 32'({Carry, Sum}));
      if (mess) begin
        A = 8'h11; B = 8'h22; start = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_off"}, 32'(busy), 32'd0);
    chk({tag, ".ready_off"}, 32'(ready), 32'd0);
    chk({tag, ".res"}, 32'({Carry, Sum}), 32'(exp_res));
    tick();
    chk({tag, ".idle"}, 32'({ready, done}), 32'b10);
  endtask

  initial begin
    logic [W:0]   q[$];
    logic [W:0]   e;
    logic [W-1:0] ca, cb;
    int           n, cyc, last_done;

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    #2;
    // 1. reset
    tick(); tick();
    chk("rst.flags", 32'({ready, busy, done}), 32'b100);
    chk("rst.res", 32'({Carry, Sum}), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst.idle", 32'(ready), 32'd1);

    // 2-4. directed
    do_op("a5_5a", 8'hA5, 8'h5A, 1'b0);
    do_op("ff_01", 8'hFF, 8'h01, 1'b0);
    do_op("ff_ff", 8'hFF, 8'hFF, 1'b0);
    do_op("ignore", 8'h3C, 8'h47, 1'b1);

    // 5. reset during the second RUN cycle
    A = 8'h77; B = 8'h99; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort.run", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.flags", 32'({ready, busy, done}), 32'b100);
    chk("abort.res", 32'({Carry, Sum}), 32'd0);
    for (int i = 0; i < NS + 2; i++) begin
      chk("abort.nodone", 32'(done), 32'd0);
      tick();
    end
    do_op("after_abort", 8'h80, 8'h80, 1'b0);

    // 6. start held high, random operands changing every op
    ca = W'($urandom); cb = W'($urandom);
    A = ca; B = cb; start = 1'b1;
    cyc = 0; last_done = -1;
    for (int op = 0; op < 200; op++) begin
      tick(); cyc++;
      q.push_back({1'b0, ca} + {1'b0, cb});
      // new operands for the next launch; must not disturb the current one
      ca = W'($urandom); cb = W'($urandom);
      A = ca; B = cb;
      n = 0;
      do begin
        tick(); cyc++; n++;
      end while (!done && n < 20);
      chk("rand.done_seen", 32'(done), 32'd1);
      chk("rand.latency", 32'(n), 32'(NS));
      if (last_done >= 0) chk("rand.spacing", 32'(cyc - last_done), 32'(NS + 2));
      last_done = cyc;
      e = q.pop_front();
      chk("rand.res", 32'({Carry, Sum}), 32'(e));
      tick(); cyc++;
      chk("rand.ready", 32'(ready), 32'd1);
    end
    start = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
